gf_mul02_bram: RTL and testbench
================================

Name: gf_mul02_bram

Overview:
- Dual-read-port ROM holding the AES GF(2^8) "multiply by 02" (xtime) table: 256 entries × 8 bits.
- Used by the AES MixColumns datapath; two independent lookups per cycle.
- Registered read, behaves like a block-RAM ROM with a synchronous output register per port.
- Single clock shared by both ports; synchronous active-low reset clears the output registers.

Parameters:
- POLY, 8'h1B, low byte of the reduction polynomial x^8+x^4+x^3+x+1. Folded into table contents. Only 8'h1B is used for AES.
- ADDR_W, 8, address width. Fixed; other values unsupported.
- DATA_W, 8, data width. Fixed; other values unsupported.

Ports:
- clk    input   1  single clock, rising-edge, both ports
- rst_n  input   1  synchronous active-low reset
- ena    input   1  port A read enable
- addra  input   8  port A address (multiplicand byte)
- douta  output  8  port A registered result = xtime(addra)
- enb    input   1  port B read enable
- addrb  input   8  port B address
- doutb  output  8  port B registered result = xtime(addrb)

Behaviour:
- Table content, for every address a in 0..255: mem[a] = {a[6:0],1'b0} XOR (a[7] ? POLY : 8'h00).
  - Contents may be a constant case table or equivalent combinational logic.
  - No write path; contents are constant.
- Reset:
  - On a rising clk edge with rst_n=0, douta and doutb load 8'h00.
  - Reset has priority over ena/enb.
  - Outputs stay 8'h00 while rst_n=0.
- Read latency is 1 cycle (without the optional feature):
  - If ena=1 at rising edge N (rst_n=1), douta = mem[addra sampled at edge N] from just after edge N.
- Enables and hold:
  - ena=0: douta holds its previous value; address changes are ignored.
  - Port B behaves identically with enb/addrb/doutb.
- Ports A and B are fully independent:
  - Same address on both ports in the same cycle is legal; both return the same value.
  - No collision behaviour exists (read-only).
- Reset mid-operation:
  - Any pending result is discarded; outputs go to 8'h00.
  - The first valid read after release needs a fresh enable.
- No X propagation: every 8-bit address yields a defined value.
- Boundary values:
  - mem[8'h00]=8'h00
  - mem[8'h7F]=8'hFE
  - mem[8'h80]=8'h1B
  - mem[8'hFF]=8'hE5

Optional Feature:
- Macro: GF_MUL02_OUT_REG_EN.
- Defined: each port gets a second output pipeline register (BRAM primitive output register style).
  - Total read latency is 2 cycles.
  - The stage-1 register advances when the enable is 1.
  - The stage-2 register loads stage-1 on the cycle after an enabled read, and holds otherwise.
  - Both stages reset to 8'h00 synchronously.
- Undefined: single register, 1-cycle latency as above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with ena=1, addra=8'h02 -> douta=8'h00, doutb=8'h00 throughout. Release; next enabled edge -> douta=8'h04.
- Pulsed reads on port A: ena=1 for 2 cycles at addra = 2, 16, 32, 48, 64, ena=0 between -> douta = 8'h04, 8'h20, 8'h40, 8'h60, 8'h80.
  - Each value appears 1 cycle after the first enabled edge (2 cycles with GF_MUL02_OUT_REG_EN).
  - Each value holds while ena=0.
- Enable hold: ena=0, sweep addra 0..255 -> douta unchanged.
- Reduction boundary, port B: addrb = 8'h80, 8'hFF, 8'h57, 8'hAE, 8'h7F -> doutb = 8'h1B, 8'hE5, 8'hAE, 8'h47, 8'hFE.
- Dual-port exhaustive: ena=enb=1; addra sweeps 0..255 while addrb = 255-addra. Compare both outputs each cycle against a reference xtime model, including same-address cycles.
- Reset mid-stream: assert rst_n=0 for 1 edge during continuous enabled reads -> outputs 8'h00 on that edge. Reads resume correctly after release.

Source files
------------

// File: rtl/gf_mul02_bram.sv
// gf_mul02_bram: dual-read-port AES xtime (multiply-by-02 in GF(2^8)) ROM.
// Both ports share one clock and have a registered output, like a block-RAM
// ROM. Synchronous active-low reset clears every output register.
// Optional feature macro: GF_MUL02_OUT_REG_EN adds a second output register
// per port, giving 2-cycle read latency.
module gf_mul02_bram #(
    parameter logic [7:0]  POLY   = 8'h1B,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] douta,
    input  logic              enb,
    input  logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] doutb
);

    // Table contents: left shift, then fold the x^8 term back in with POLY.
    function automatic logic [DATA_W-1:0] xtime(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] shifted;
        shifted = {a[DATA_W-2:0], 1'b0};
        return a[ADDR_W-1] ? (shifted ^ POLY) : shifted;
    endfunction

    logic [DATA_W-1:0] rom_a;
    logic [DATA_W-1:0] rom_b;

    // Constant-table lookup for both ports.
    always_comb begin
        rom_a = xtime(addra);
        rom_b = xtime(addrb);
    end

    logic [DATA_W-1:0] douta_q, douta_d;
    logic [DATA_W-1:0] doutb_q, doutb_d;

    // Stage-1 next state: load on enable, otherwise hold.
    always_comb begin
        douta_d = douta_q;
        doutb_d = doutb_q;
        if (ena) douta_d = rom_a;
        if (enb) doutb_d = rom_b;
    end

    // Stage-1 output registers with synchronous reset priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            douta_q <= '0;
            doutb_q <= '0;
        end else begin
            douta_q <= douta_d;
            doutb_q <= doutb_d;
        end
    end

`ifdef GF_MUL02_OUT_REG_EN
    logic              ena_q, enb_q;
    logic [DATA_W-1:0] douta2_q, douta2_d;
    logic [DATA_W-1:0] doutb2_q, doutb2_d;

    // Stage-2 next state: copy stage 1 only on the cycle after an enabled read.
    always_comb begin
        douta2_d = douta2_q;
        doutb2_d = doutb2_q;
        if (ena_q) douta2_d = douta_q;
        if (enb_q) doutb2_d = doutb_q;
    end

    // Stage-2 registers plus the delayed enables that advance them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ena_q    <= 1'b0;
            enb_q    <= 1'b0;
            douta2_q <= '0;
            doutb2_q <= '0;
        end else begin
            ena_q    <= ena;
            enb_q    <= enb;
            douta2_q <= douta2_d;
            doutb2_q <= doutb2_d;
        end
    end

    assign douta = douta2_q;
    assign doutb = doutb2_q;
`else
    assign douta = douta_q;
    assign doutb = doutb_q;
`endif

endmodule

// File: tb/tb_gf_mul02_bram.sv
// Directed self-checking bench for gf_mul02_bram (either latency build).
module tb_gf_mul02_bram;

`ifdef GF_MUL02_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, enb;
    logic [7:0] addra, addrb;
    logic [7:0] douta, doutb;

    int vectors = 0;
    int errors  = 0;

    gf_mul02_bram #(.POLY(8'h1B), .ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .addra (addra),
        .douta (douta),
        .enb   (enb),
        .addrb (addrb),
        .doutb (doutb)
    );

    always #5 clk = ~clk;

    // Reference xtime: multiply by x, reduce by x^8 = x^4+x^3+x+1.
    function automatic logic [7:0] ref_xtime(input logic [7:0] a);
        logic [8:0] p;
        p = {a, 1'b0};
        if (p[8]) p = p ^ 9'h11B;
        return p[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; enb = 1'b1; addra = 8'h02; addrb = 8'h02;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (douta !== 8'h00) begin
                errors++; $display("FAIL reset_a cyc%0d got %h exp 00", i, douta);
            end
            vectors++;
            if (doutb !== 8'h00) begin
                errors++; $display("FAIL reset_b cyc%0d got %h exp 00", i, doutb);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < LAT; i++) tick();
        vectors++;
        if (douta !== 8'h04) begin
            errors++; $display("FAIL reset_release_a got %h exp 04", douta);
        end
    endtask

    task automatic test_pulsed_a();
        logic [7:0] addrs [5] = '{8'h02, 8'h10, 8'h20, 8'h30, 8'h40};
        logic [7:0] exps  [5] = '{8'h04, 8'h20, 8'h40, 8'h60, 8'h80};
        enb = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ena = 1'b1; addra = addrs[k];
            for (int c = 1; c <= 2; c++) begin
                tick();
                if (c >= LAT) begin
                    vectors++;
                    if (douta !== exps[k]) begin
                        errors++; $display("FAIL pulsed_a addr %h cyc%0d got %h exp %h", addrs[k], c, douta, exps[k]);
                    end
                end
            end
            ena = 1'b0; addra = ~addrs[k];
            for (int c = 0; c < 3; c++) begin
                tick();
                vectors++;
                if (douta !== exps[k]) begin
                    errors++; $display("FAIL pulsed_a_hold addr %h cyc%0d got %h exp %h", addrs[k], c, douta, exps[k]);
                end
            end
        end
    endtask

    task automatic test_hold_a();
        ena = 1'b0;
        for (int i = 0; i < 256; i++) begin
            addra = 8'(i);
            tick();
            vectors++;
            if (douta !== 8'h80) begin
                errors++; $display("FAIL hold_a addr %h got %h exp 80", addra, douta);
            end
        end
    endtask

    task automatic test_boundary_b();
        logic [7:0] addrs [5] = '{8'h80, 8'hFF, 8'h57, 8'hAE, 8'h7F};
        logic [7:0] exps  [5] = '{8'h1B, 8'hE5, 8'hAE, 8'h47, 8'hFE};
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            enb = 1'b1; addrb = addrs[k];
            for (int c = 0; c < LAT; c++) tick();
            vectors++;
            if (doutb !== exps[k]) begin
                errors++; $display("FAIL boundary_b addr %h got %h exp %h", addrs[k], doutb, exps[k]);
            end
            enb = 1'b0; addrb = 8'h00;
            tick();
            vectors++;
            if (doutb !== exps[k]) begin
                errors++; $display("FAIL boundary_b_hold addr %h got %h exp %h", addrs[k], doutb, exps[k]);
            end
        end
    endtask

    task automatic test_dual_exhaustive();
        logic [7:0] ha [0:299];
        logic [7:0] hb [0:299];
        int n;
        ena = 1'b1; enb = 1'b1;
        n = 256 + 8 + LAT - 1;
        for (int i = 0; i < n; i++) begin
            if (i < 256) begin
                addra = 8'(i);
                addrb = 8'(255 - i);
            end else begin
                // same address on both ports
                addra = 8'((i - 256) * 37 + 1);
                addrb = addra;
            end
            ha[i] = addra;
            hb[i] = addrb;
            tick();
            if (i >= LAT - 1) begin
                vectors++;
                if (douta !== ref_xtime(ha[i-LAT+1])) begin
                    errors++; $display("FAIL dual_a addr %h got %h exp %h", ha[i-LAT+1], douta, ref_xtime(ha[i-LAT+1]));
                end
                vectors++;
                if (doutb !== ref_xtime(hb[i-LAT+1])) begin
                    errors++; $display("FAIL dual_b addr %h got %h exp %h", hb[i-LAT+1], doutb, ref_xtime(hb[i-LAT+1]));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        ena = 1'b1; enb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addra = 8'hC0 + 8'(i); addrb = 8'h40 + 8'(i);
            tick();
        end
        rst_n = 1'b0;
        tick();
        vectors++;
        if (douta !== 8'h00) begin
            errors++; $display("FAIL mid_reset_a got %h exp 00", douta);
        end
        vectors++;
        if (doutb !== 8'h00) begin
            errors++; $display("FAIL mid_reset_b got %h exp 00", doutb);
        end
        rst_n = 1'b1; addra = 8'hA5; addrb = 8'h3C;
        for (int i = 0; i < LAT; i++) tick();
        vectors++;
        if (douta !== 8'h51) begin
            errors++; $display("FAIL mid_resume_a got %h exp 51", douta);
        end
        vectors++;
        if (doutb !== 8'h78) begin
            errors++; $display("FAIL mid_resume_b got %h exp 78", doutb);
        end
        ena = 1'b0; enb = 1'b0;
        for (int i = 0; i < LAT + 1; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; enb = 1'b0; addra = '0; addrb = '0;
        test_reset();
        test_pulsed_a();
        test_hold_a();
        test_boundary_b();
        test_dual_exhaustive();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
